// File: rtl/instr_decode_stage.sv
// Registered RV32/RV64 instruction decode stage: splits fields, builds the sign-extended
// immediate and flags unknown opcodes, behind a two-entry skid buffer with flush.
module instr_decode_stage #(
  parameter int XLEN          = 32,
  parameter bit CHECK_ILLEGAL = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_type,
  output logic            out_illegal
);

  localparam logic [2:0] IMM_R = 3'd0;
  localparam logic [2:0] IMM_I = 3'd1;
  localparam logic [2:0] IMM_S = 3'd2;
  localparam logic [2:0] IMM_B = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;
  localparam logic [2:0] IMM_J = 3'd5;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    logic [2:0]      imm_type;
    logic            illegal;
  } bundle_t;

  logic [2:0]      dec_type;
  logic            dec_known;
  logic [31:0]     dec_imm32;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  bundle_t         dec_bundle;

  logic    out_valid_reg,   out_valid_next;
  logic    skid_valid_reg,  skid_valid_next;
  bundle_t out_bundle_reg,  out_bundle_next;
  bundle_t skid_bundle_reg, skid_bundle_next;
  logic    accept;

  always_comb begin
    dec_type  = IMM_R;
    dec_known = 1'b1;
    case (in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b0011011,
      7'b1100111, 7'b1110011, 7'b0001111: dec_type = IMM_I;
      7'b0100011:                         dec_type = IMM_S;
      7'b1100011:                         dec_type = IMM_B;
      7'b0110111, 7'b0010111:             dec_type = IMM_U;
      7'b1101111:                         dec_type = IMM_J;
      7'b0110011, 7'b0111011:             dec_type = IMM_R;
      default:                            dec_known = 1'b0;
    endcase
  end

  always_comb begin
    case (dec_type)
      IMM_I:   dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      IMM_S:   dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      IMM_B:   dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
      IMM_U:   dec_imm32 = {in_instr[31:12], 12'b0};
      IMM_J:   dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
      default: dec_imm32 = 32'b0;
    endcase
  end

  // Every 32-bit immediate is already signed; wider XLEN just replicates bit 31.
  assign dec_imm[31:0] = dec_imm32;
  genvar gi;
  generate
    for (gi = 32; gi < XLEN; gi++) begin : g_imm_sext
      assign dec_imm[gi] = dec_imm32[31];
    end
  endgenerate

  assign dec_illegal = CHECK_ILLEGAL && (!dec_known || (in_instr[1:0] != 2'b11));

  assign dec_bundle = '{pc: in_pc, instr: in_instr, imm: dec_imm,
                        imm_type: dec_type, illegal: dec_illegal};

  assign in_ready = !skid_valid_reg;
  assign accept   = in_valid && in_ready && !flush;

  // Skid is only ever filled while the output register is stalled, so it always
  // holds the older entry and must drain before any new input is taken.
  always_comb begin
    out_valid_next   = out_valid_reg;
    skid_valid_next  = skid_valid_reg;
    out_bundle_next  = out_bundle_reg;
    skid_bundle_next = skid_bundle_reg;
    if (flush) begin
      out_valid_next  = 1'b0;
      skid_valid_next = 1'b0;
    end else if (!out_valid_reg || out_ready) begin
      if (skid_valid_reg) begin
        out_bundle_next = skid_bundle_reg;
        out_valid_next  = 1'b1;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        out_bundle_next = dec_bundle;
        out_valid_next  = 1'b1;
      end else begin
        out_valid_next  = 1'b0;
      end
    end else if (accept) begin
      skid_bundle_next = dec_bundle;
      skid_valid_next  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_reg   <= 1'b0;
      skid_valid_reg  <= 1'b0;
      out_bundle_reg  <= '0;
      skid_bundle_reg <= '0;
    end else begin
      out_valid_reg   <= out_valid_next;
      skid_valid_reg  <= skid_valid_next;
      out_bundle_reg  <= out_bundle_next;
      skid_bundle_reg <= skid_bundle_next;
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_pc       = out_bundle_reg.pc;
  assign out_opcode   = out_bundle_reg.instr[6:0];
  assign out_rd       = out_bundle_reg.instr[11:7];
  assign out_funct3   = out_bundle_reg.instr[14:12];
  assign out_rs1      = out_bundle_reg.instr[19:15];
  assign out_rs2      = out_bundle_reg.instr[24:20];
  assign out_funct7   = out_bundle_reg.instr[31:25];
  assign out_imm      = out_bundle_reg.imm;
  assign out_imm_type = out_bundle_reg.imm_type;
  assign out_illegal  = out_bundle_reg.illegal;

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Registered, flow-controlled successor to the combinational instruction field splitter. It sits between fetch and register-read. Each cycle it accepts one 32-bit RV32/RV64 base instruction with its PC and presents the split fields, an XLEN-wide sign-extended immediate, an immediate-format code and an illegal-opcode flag one cycle later. A two-entry skid buffer (output register plus skid register) decouples fetch from downstream stalls without a combinational ready path, and a flush input supports branch redirect.

## Interface
Parameters:
- XLEN, default 32: width of `in_pc`, `out_pc` and `out_imm`; legal values are 32 and 64.
- CHECK_ILLEGAL, default 1: when 1, `out_illegal` is computed; when 0, `out_illegal` is tied to 0.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous; discards all held and incoming instructions.
- in_valid  input  1  upstream offers an instruction.
- in_ready  output  1  stage can accept; registered (equals `!skid_valid`).
- in_instr  input  32  instruction word.
- in_pc  input  XLEN  instruction address.
- out_valid  output  1  decoded instruction present.
- out_ready  input  1  downstream accepts.
- out_pc  output  XLEN  PC of the presented instruction.
- out_opcode  output  7  instr[6:0].
- out_rd  output  5  instr[11:7].
- out_funct3  output  3  instr[14:12].
- out_rs1  output  5  instr[19:15].
- out_rs2  output  5  instr[24:20].
- out_funct7  output  7  instr[31:25].
- out_imm  output  XLEN  sign-extended immediate.
- out_imm_type  output  3  immediate format: 0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J.
- out_illegal  output  1  unrecognised opcode, or instr[1:0] != 2'b11.

## Operation
- Decoding happens on the input side. Every field is computed from `in_instr` before registering, so the output and skid registers hold fully decoded bundles.
- Opcode to immediate format:
  - I: 0000011, 0010011, 0011011, 1100111, 1110011, 0001111.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - R (imm=0): 0110011, 0111011.
  - Any other opcode: imm=0, type=0, `out_illegal`=1.
- Immediate construction:
  - I = sext(instr[31:20]).
  - S = sext({instr[31:25], instr[11:7]}).
  - B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U = sext({instr[31:12], 12'b0}); bits above 31 are copies of instr[31] when XLEN=64.
  - J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- Acceptance: the stage accepts when `in_valid && in_ready && !flush`.
- Output register (`out_*`) load rules:
  - When it is empty, or when `out_ready`=1, it loads from the skid register if the skid register is valid, otherwise from the accepted input.
  - If the output register is valid, `out_ready`=0 and an input is accepted, the input goes into the skid register.
  - The skid register drains into the output register on the first cycle with `out_ready`=1. Ordering is strictly FIFO.
- Flush: on a clock edge with `flush`=1, `out_valid` and `skid_valid` clear. Any `in_valid` on that cycle is dropped. `in_ready` is 1 on the following cycle.
- Data outputs change only on an output-register load. While `out_valid`=0 they hold their last value.

## Timing
- Reset values: `out_valid`=0, skid_valid=0, `in_ready`=1, and all data outputs 0 (`out_imm`=0, `out_imm_type`=0, `out_illegal`=0).
- Reset is asynchronous on assert and is released synchronously by the surrounding reset logic. Reset mid-transfer loses held instructions.
- Latency: instruction accepted at edge N appears on the outputs after edge N, i.e. one cycle.
- Throughput: one instruction per cycle while `out_ready`=1.
- Stall: with `out_ready`=0, at most two instructions are held. `in_ready` falls the cycle after the skid register fills, so there is no combinational path from `out_ready` to `in_ready`.
- Simultaneous events on one edge:
  - Skid valid and `out_ready`=1 with input offered: skid moves to output, and the input is not accepted because `in_ready` was 0.
  - Output valid, `out_ready`=1, skid empty and input accepted: the new instruction replaces the output; no bubble.
  - Flush has priority over all loads.
- Handshake rule: `out_*` is stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- Field and immediate checks, XLEN=32:
  - 0xFFF00093 (addi x1,x0,-1) -> opcode=0x13, rd=1, rs1=0, imm=0xFFFFFFFF, type=1, illegal=0.
  - 0x0020A423 (sw x2,8(x1)) -> imm=8, type=2, rs1=1, rs2=2, funct3=2.
- More immediate formats:
  - 0xFE000EE3 (beq -4) -> imm=0xFFFFFFFC, type=3.
  - 0x001000EF (jal x1,2048) -> imm=0x800, type=5, rd=1.
  - 0x123452B7 (lui x5) with XLEN=64 -> imm=0x0000000012345000.
  - 0x800002B7 with XLEN=64 -> imm=0xFFFFFFFF80000000.
- Illegal detection:
  - 0x0000007F -> illegal=1, imm=0.
  - 0x00000093 with bit1 cleared (0x00000091) -> illegal=1.
  - With CHECK_ILLEGAL=0, both words -> illegal=0.
- Backpressure: stream instructions A, B, C, D back-to-back and hold `out_ready`=0 for 3 cycles.
  - Required: A is held on the outputs, B sits in the skid register, and `in_ready`=0.
  - After release: A, B, C, D are presented in order with no loss and no duplication.
- Flush: with A on the outputs and B in the skid register, assert `flush` together with `in_valid` carrying C.
  - Required: next cycle `out_valid`=0 and `in_ready`=1; C is never presented.
  - A subsequent D appears one cycle after it is accepted.
- Reset: assert `reset_n`=0 mid-stream.
  - Required: `out_valid`=0, `in_ready`=1 and all data outputs 0 immediately, without waiting for a clock edge.
